// File: rtl/rf_wb_writer.sv
// rf_wb_writer: register-file write-back initiator with load wait, extraction and bypass status
module rf_wb_writer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wdsel,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic [2:0]  in_dmtype,
    input  logic [1:0]  in_byteoff,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        load_busy,
    output logic [4:0]  load_rd,
    output logic        err_timeout,
    output logic        err_misalign,
    output logic        err_unexp
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [4:0]       ld_rd, ld_rd_nx, a3_nx;
    logic [2:0]       ld_type, ld_type_nx;
    logic [1:0]       ld_off, ld_off_nx;
    logic [31:0]      wd_nx, ld_data;
    logic [15:0]      ld_half;
    logic [7:0]       ld_byte;
    logic             wr_nx, to_set, mis_set, unexp_set, misal, xfer, rd_ok;
    assign in_ready  = state == IDLE;
    assign load_busy = state == WAIT_MEM;
    assign load_rd   = load_busy ? ld_rd : 5'd0;
    assign fwd_valid = RFWr;
    assign fwd_rd    = A3;
    assign fwd_data  = WD;
    assign xfer      = in_valid & in_ready;
    assign rd_ok     = in_regwrite & (|in_rd);
    assign ld_byte   = mem_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half   = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Undefined load types fall through to a full word.
    assign ld_data = ld_type == 3'd1 ? {{16{ld_half[15]}}, ld_half} :
                     ld_type == 3'd2 ? {16'h0, ld_half} :
                     ld_type == 3'd3 ? {{24{ld_byte[7]}}, ld_byte} :
                     ld_type == 3'd4 ? {24'h0, ld_byte} : mem_rdata;
    assign misal = (ld_type == 3'd1 || ld_type == 3'd2) ? ld_off[0] :
                   (ld_type == 3'd3 || ld_type == 3'd4) ? 1'b0 : |ld_off;
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ld_rd_nx   = ld_rd;
        ld_type_nx = ld_type;
        ld_off_nx  = ld_off;
        wr_nx      = 1'b0;
        a3_nx      = A3;
        wd_nx      = WD;
        to_set     = 1'b0;
        mis_set    = 1'b0;
        unexp_set  = 1'b0;
        if (state == IDLE) begin
            unexp_set = mem_rvalid;
            if (xfer && rd_ok && in_wdsel == 2'b01) begin
                state_nx   = WAIT_MEM;
                cnt_nx     = '0;
                ld_rd_nx   = in_rd;
                ld_type_nx = in_dmtype;
                ld_off_nx  = in_byteoff;
            end else if (xfer && rd_ok) begin
                wr_nx = 1'b1;
                a3_nx = in_rd;
                wd_nx = in_wdsel == 2'b10 ? in_pc4 : in_alu;
            end
        end else if (mem_rvalid) begin
            // A returning load beats a timeout in the same cycle.
            state_nx = IDLE;
            mis_set  = misal;
            wr_nx    = !misal;
            a3_nx    = misal ? A3 : ld_rd;
            wd_nx    = misal ? WD : ld_data;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nx = IDLE;
            to_set   = 1'b1;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_rd        <= '0;
            ld_type      <= '0;
            ld_off       <= '0;
            RFWr         <= 1'b0;
            A3           <= '0;
            WD           <= '0;
            err_timeout  <= 1'b0;
            err_misalign <= 1'b0;
            err_unexp    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            ld_rd        <= ld_rd_nx;
            ld_type      <= ld_type_nx;
            ld_off       <= ld_off_nx;
            RFWr         <= wr_nx;
            A3           <= a3_nx;
            WD           <= wd_nx;
            err_timeout  <= err_timeout | to_set;
            err_misalign <= err_misalign | mis_set;
            err_unexp    <= err_unexp | unexp_set;
        end
    end
endmodule

// File: tb/tb_rf_wb_writer.sv
// tb_rf_wb_writer: scoreboard bench; stimulus queues expected writes, a monitor checks every RFWr pulse
module tb_rf_wb_writer;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_regwrite = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wdsel = '0, in_byteoff = '0;
    logic [31:0] in_alu = '0, in_pc4 = '0, mem_rdata = '0;
    logic [2:0]  in_dmtype = '0;
    logic        mem_rvalid = 1'b0;
    logic        RFWr, fwd_valid, load_busy, err_timeout, err_misalign, err_unexp;
    logic [4:0]  A3, fwd_rd, load_rd;
    logic [31:0] WD, fwd_data;
    logic [36:0] exp_q[$];
    int          errors = 0, checks = 0, busy_cnt = 0, streak = 0, max_streak = 0;

    rf_wb_writer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wdsel(in_wdsel), .in_alu(in_alu),
        .in_pc4(in_pc4), .in_dmtype(in_dmtype), .in_byteoff(in_byteoff),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .RFWr(RFWr), .A3(A3), .WD(WD),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_busy(load_busy),
        .load_rd(load_rd), .err_timeout(err_timeout), .err_misalign(err_misalign),
        .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (load_busy) busy_cnt++;
            streak = RFWr ? streak + 1 : 0;
            if (streak > max_streak) max_streak = streak;
            if (RFWr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: A3=%0d WD=%h, no write expected", A3, WD);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    if ({A3, WD} !== e || {fwd_valid, fwd_rd, fwd_data} !== {1'b1, A3, WD} || A3 == 5'd0) begin
                        errors++;
                        $display("FAIL write: got A3=%0d WD=%h fwd=%b/%0d/%h expected A3=%0d WD=%h",
                                 A3, WD, fwd_valid, fwd_rd, fwd_data, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] dt, input logic [1:0] off);
        chk("ready_before_issue", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_regwrite = rw; in_rd = rd; in_wdsel = ws;
        in_alu = alu; in_pc4 = pc4; in_dmtype = dt; in_byteoff = off;
        step();
        in_valid = 1'b0;
    endtask

    // delay = wait cycle in which rvalid arrives; 0 means never
    task automatic load(input logic [4:0] rd, input logic [2:0] dt, input logic [1:0] off,
                        input int delay, input logic [31:0] rdata, input int exp_busy);
        busy_cnt = 0;
        issue(1'b1, rd, 2'b01, 32'hBAD0_BAD0, 32'hBAD1_BAD1, dt, off);
        chk("load_rd", {27'b0, load_rd}, {27'b0, rd});
        if (delay == 0) begin
            repeat (16) step();
        end else begin
            repeat (delay - 1) step();
            mem_rvalid = 1'b1; mem_rdata = rdata;
            step();
            mem_rvalid = 1'b0;
        end
        chk("load_busy_cycles", busy_cnt, exp_busy);
        chk("ready_after_load", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_RFWr", {31'b0, RFWr}, 32'd0);
        chk("rst_A3", {27'b0, A3}, 32'd0);
        chk("rst_WD", WD, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {26'b0, load_busy, load_rd}, 32'd0);
        chk("rst_errs", {29'b0, err_timeout, err_misalign, err_unexp}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        step();
        rstn = 1'b1;
        step();
        // ALU, PC+4 and wdsel=11 paths
        exp_q.push_back({5'd5, 32'h1234_5678});
        issue(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0000_0004, 3'd0, 2'd0);
        repeat (2) step();
        exp_q.push_back({5'd7, 32'h0000_0100});
        issue(1'b1, 5'd7, 2'b10, 32'hFFFF_FFFF, 32'h0000_0100, 3'd0, 2'd0);
        exp_q.push_back({5'd8, 32'hCAFE_0001});
        issue(1'b1, 5'd8, 2'b11, 32'hCAFE_0001, 32'h0000_0200, 3'd0, 2'd0);
        step();
        // loads: extraction and extension
        exp_q.push_back({5'd10, 32'hFFFF_FF80});
        load(5'd10, 3'd3, 2'd2, 3, 32'h0080_FF00, 3);
        exp_q.push_back({5'd11, 32'h0000_0080});
        load(5'd11, 3'd4, 2'd2, 3, 32'h0080_FF00, 3);
        exp_q.push_back({5'd12, 32'hFFFF_8001});
        load(5'd12, 3'd1, 2'd2, 3, 32'h8001_0000, 3);
        exp_q.push_back({5'd13, 32'h0000_8001});
        load(5'd13, 3'd2, 2'd2, 1, 32'h8001_0000, 1);
        exp_q.push_back({5'd14, 32'hFFFF_FFFF});
        load(5'd14, 3'd3, 2'd1, 2, 32'h0080_FF00, 2);
        exp_q.push_back({5'd15, 32'hDEAD_BEEF});
        load(5'd15, 3'd0, 2'd0, 2, 32'hDEAD_BEEF, 2);
        exp_q.push_back({5'd16, 32'h0BAD_F00D});
        load(5'd16, 3'd7, 2'd0, 1, 32'h0BAD_F00D, 1);
        step();
        // timeout, then rvalid coinciding with the timeout cycle
        chk("err_timeout_clear", {31'b0, err_timeout}, 32'd0);
        load(5'd9, 3'd0, 2'd0, 0, 32'h0, 16);
        chk("err_timeout_set", {31'b0, err_timeout}, 32'd1);
        exp_q.push_back({5'd17, 32'h5555_AAAA});
        load(5'd17, 3'd0, 2'd0, 16, 32'h5555_AAAA, 16);
        step();
        // suppressed writes
        issue(1'b1, 5'd0, 2'b00, 32'h1111_1111, 32'h0, 3'd0, 2'd0);
        issue(1'b0, 5'd4, 2'b00, 32'h2222_2222, 32'h0, 3'd0, 2'd0);
        issue(1'b1, 5'd0, 2'b01, 32'h0, 32'h0, 3'd0, 2'd0);
        chk("rd0_load_not_busy", {31'b0, load_busy}, 32'd0);
        issue(1'b0, 5'd6, 2'b01, 32'h0, 32'h0, 3'd0, 2'd0);
        chk("nowrite_load_not_busy", {31'b0, load_busy}, 32'd0);
        chk("err_misalign_clear", {31'b0, err_misalign}, 32'd0);
        load(5'd18, 3'd0, 2'd1, 2, 32'h7777_7777, 2);
        chk("err_misalign_lw", {31'b0, err_misalign}, 32'd1);
        load(5'd19, 3'd1, 2'd3, 1, 32'h7777_7777, 1);
        step();
        // back-to-back ALU writes
        max_streak = 0;
        in_valid = 1'b1; in_regwrite = 1'b1; in_wdsel = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            in_rd = 5'(i); in_alu = 32'hA000_0000 + 32'(i);
            exp_q.push_back({5'(i), 32'hA000_0000 + 32'(i)});
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("b2b_streak", max_streak, 32'd3);
        // stray rvalid in IDLE
        chk("err_unexp_clear", {31'b0, err_unexp}, 32'd0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("err_unexp_set", {31'b0, err_unexp}, 32'd1);
        // reset while a load is outstanding, rvalid during reset
        issue(1'b1, 5'd20, 2'b01, 32'h0, 32'h0, 3'd0, 2'd0);
        chk("busy_before_reset", {31'b0, load_busy}, 32'd1);
        rstn = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        step();
        rstn = 1'b1;
        repeat (3) step();
        chk("no_write_after_reset", {31'b0, RFWr}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
